// File: rtl/omux_pkg.sv
// Shared definitions for the FT2232 output multiplexer: FSM encoding, byte width
// and the packet framing sentinels that the sources place at the start of each packet.
package omux_pkg;

    typedef enum logic {
        OMUX_IDLE  = 1'b0,
        OMUX_GRANT = 1'b1
    } omux_state_e;

    localparam int OMUX_BYTE_W = 8;

    localparam logic [OMUX_BYTE_W-1:0] OMUX_SOF_REQUEST = 8'hAA;
    localparam logic [OMUX_BYTE_W-1:0] OMUX_SOF_REPLY   = 8'hAB;

endpackage

// File: rtl/omux_rr_pick.sv
// Round-robin picker: rotates the request vector so the search starts one past
// `base`, then priority-encodes the lowest set bit and maps it back to a source index.
module omux_rr_pick
    import omux_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = 3
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] base,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [NREQ-1:0] rot;
    int              shiftAmt;
    int              off;

    // Rotate requests so bit 0 is source base+1, find the first requester, un-rotate.
    always_comb begin
        shiftAmt = (int'(base) + 1) % NREQ;
        rot      = NREQ'({req, req} >> shiftAmt);
        off      = 0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                off = j;
            end
        end
        any = |req;
        idx = IDX_W'((int'(base) + 1 + off) % NREQ);
    end

endmodule

// File: rtl/omux_arbiter.sv
// Output multiplexer sharing the FT2232 transmit byte path between NREQ packet
// sources. The grant is held for a whole packet so packets never interleave.
// Optional build macro OMUX_PRIO0_EN: source 0 wins every arbitration it takes
// part in (strict priority for the register reply path); others stay round-robin.
module omux_arbiter
    import omux_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = 3
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [NREQ-1:0]             req_i,
    input  logic [OMUX_BYTE_W*NREQ-1:0] data_i,
    output logic [NREQ-1:0]             sel_o,
    input  logic                        out_txe_i,
    output logic [OMUX_BYTE_W-1:0]      out_data_o,
    output logic                        out_wr_o,
    output logic                        busy_o,
    output logic [IDX_W-1:0]            owner_o
);

    omux_state_e             state_q, state_d;
    logic [IDX_W-1:0]        owner_q, owner_d;

    logic                    pickAny;
    logic [IDX_W-1:0]        pickIdx;
    logic [IDX_W-1:0]        winIdx;

    logic                    ownerReq;
    logic [OMUX_BYTE_W-1:0]  ownerData;
    logic [NREQ-1:0]         ownerOneHot;

    omux_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req  (req_i),
        .base (owner_q),
        .any  (pickAny),
        .idx  (pickIdx)
    );

`ifdef OMUX_PRIO0_EN
    // Source 0 overrides the rotation whenever it is requesting at arbitration time.
    always_comb begin
        winIdx = req_i[0] ? '0 : pickIdx;
    end
`else
    // Pure round-robin: the picker result is the winner.
    always_comb begin
        winIdx = pickIdx;
    end
`endif

    // Select the current owner's request, byte and one-hot strobe position.
    always_comb begin
        ownerReq    = 1'b0;
        ownerData   = '0;
        ownerOneHot = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (owner_q == IDX_W'(k)) begin
                ownerReq       = req_i[k];
                ownerData      = data_i[OMUX_BYTE_W*k +: OMUX_BYTE_W];
                ownerOneHot[k] = 1'b1;
            end
        end
    end

    // Next-state and output decode; writes only happen in GRANT with the FIFO ready.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        sel_o      = '0;
        out_wr_o   = 1'b0;
        out_data_o = '0;
        case (state_q)
            OMUX_IDLE: begin
                if (pickAny) begin
                    owner_d = winIdx;
                    state_d = OMUX_GRANT;
                end
            end
            OMUX_GRANT: begin
                if (!ownerReq) begin
                    state_d = OMUX_IDLE;
                end else if (out_txe_i) begin
                    out_wr_o   = 1'b1;
                    out_data_o = ownerData;
                    sel_o      = ownerOneHot;
                end
            end
            default: begin
                state_d = OMUX_IDLE;
            end
        endcase
    end

    // State and owner registers; reset parks owner at NREQ-1 so source 0 is first.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= OMUX_IDLE;
            owner_q <= IDX_W'(NREQ - 1);
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    assign busy_o  = (state_q == OMUX_GRANT);
    assign owner_o = owner_q;

endmodule
